// File: rtl/branch_predictor_table.sv
// Bimodal / gshare direction predictor: saturating counter table with
// one-cycle prediction, resolved-branch update port and hit/miss stats.
module branch_predictor_table #(
   parameter int PC_W    = 32,
   parameter int INDEX_W = 4,
   parameter int CTR_W   = 2,
   parameter int HIST_W  = 0,
   parameter int STAT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   input  logic [PC_W-1:0]    req_pc,
   output logic               pred_valid,
   output logic               pred_taken,
   output logic [INDEX_W-1:0] pred_idx,
   input  logic               upd_valid,
   input  logic [INDEX_W-1:0] upd_idx,
   input  logic               upd_taken,
   input  logic               upd_pred,
   output logic [STAT_W-1:0]  stat_upd,
   output logic [STAT_W-1:0]  stat_miss
);

   localparam int N    = 1 << INDEX_W;
   localparam int GH_W = (HIST_W > 0) ? HIST_W : 1;

   localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   if (HIST_W > INDEX_W || HIST_W < 0 || CTR_W < 1) begin : g_bad_params
      $error("branch_predictor_table: illegal HIST_W/CTR_W");
   end

   logic [CTR_W-1:0]   ctr_q [N];
   logic [CTR_W-1:0]   ctr_d [N];
   logic [GH_W-1:0]    ghr_q, ghr_d;
   logic               pred_valid_q, pred_valid_d;
   logic               pred_taken_q, pred_taken_d;
   logic [INDEX_W-1:0] pred_idx_q, pred_idx_d;
   logic [STAT_W-1:0]  stat_upd_q, stat_upd_d;
   logic [STAT_W-1:0]  stat_miss_q, stat_miss_d;

   logic [INDEX_W-1:0] hist_ext;
   logic [INDEX_W-1:0] req_idx;
   logic               unused_pc;

   assign unused_pc = ^{req_pc[PC_W-1:INDEX_W+2], req_pc[1:0]};
   assign hist_ext  = (HIST_W > 0) ? INDEX_W'(ghr_q) : '0;
   assign req_idx   = req_pc[INDEX_W+1:2] ^ hist_ext;

   always_comb begin
      ctr_d = ctr_q;
      if (upd_valid) begin
         if (upd_taken) begin
            if (ctr_q[upd_idx] != CTR_MAX)
               ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
         end else begin
            if (ctr_q[upd_idx] != '0)
               ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
         end
      end
   end

   // History shifts only on resolved branches; bimodal keeps it at zero.
   always_comb begin
      ghr_d = ghr_q;
      if (HIST_W > 0 && upd_valid)
         ghr_d = GH_W'({ghr_q, upd_taken});
   end

   // Prediction reads the post-update table so a same-cycle write is seen.
   always_comb begin
      pred_valid_d = req_valid;
      pred_taken_d = req_valid & ctr_d[req_idx][CTR_W-1];
      pred_idx_d   = req_valid ? req_idx : pred_idx_q;
   end

   always_comb begin
      stat_upd_d  = stat_upd_q;
      stat_miss_d = stat_miss_q;
      if (upd_valid) begin
         if (stat_upd_q != STAT_MAX)
            stat_upd_d = stat_upd_q + 1'b1;
         if (upd_pred != upd_taken && stat_miss_q != STAT_MAX)
            stat_miss_d = stat_miss_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++)
            ctr_q[i] <= '0;
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_idx_q   <= '0;
         stat_upd_q   <= '0;
         stat_miss_q  <= '0;
      end else begin
         ctr_q        <= ctr_d;
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_idx_q   <= pred_idx_d;
         stat_upd_q   <= stat_upd_d;
         stat_miss_q  <= stat_miss_d;
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_idx   = pred_idx_q;
   assign stat_upd   = stat_upd_q;
   assign stat_miss  = stat_miss_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench for branch_predictor_table (gshare, HIST_W=2, STAT_W=3)
// against an array-based reference model of the counter table.
module tb_branch_predictor_table;

   localparam int PC_W = 32;
   localparam int IW   = 4;
   localparam int CW   = 2;
   localparam int HW   = 2;
   localparam int SW   = 3;
   localparam int NE   = 1 << IW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic [PC_W-1:0] req_pc = '0;
   logic          pred_valid;
   logic          pred_taken;
   logic [IW-1:0] pred_idx;
   logic          upd_valid = 1'b0;
   logic [IW-1:0] upd_idx = '0;
   logic          upd_taken = 1'b0;
   logic          upd_pred = 1'b0;
   logic [SW-1:0] stat_upd;
   logic [SW-1:0] stat_miss;

   branch_predictor_table #(
      .PC_W(PC_W), .INDEX_W(IW), .CTR_W(CW), .HIST_W(HW), .STAT_W(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_pc(req_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
      .upd_valid(upd_valid), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_pred(upd_pred),
      .stat_upd(stat_upd), .stat_miss(stat_miss)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int m_ctr [NE];
   int m_ghr;
   int m_upd;
   int m_miss;
   int last_idx;
   logic [IW:0] exp_q [$];

   localparam int CTR_TOP  = (1 << CW) - 1;
   localparam int STAT_TOP = (1 << SW) - 1;
   localparam int HIST_MOD = 1 << HW;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NE; i++) m_ctr[i] = 0;
      m_ghr = 0;
      m_upd = 0;
      m_miss = 0;
      last_idx = 0;
      exp_q.delete();
   endfunction

   task automatic cyc(input bit rq, input logic [PC_W-1:0] pc, input bit uv,
                      input logic [IW-1:0] ui, input bit ut, input bit up);
      int idx;
      logic [IW-1:0] id4;
      @(negedge clk);
      req_valid = rq; req_pc = pc;
      upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
      idx = (int'(pc) >> 2) % NE;
      idx = idx ^ m_ghr;
      if (uv) begin
         if (ut) m_ctr[ui] = (m_ctr[ui] < CTR_TOP) ? m_ctr[ui] + 1 : CTR_TOP;
         else    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
         m_ghr = (m_ghr * 2 + (ut ? 1 : 0)) % HIST_MOD;
         if (m_upd < STAT_TOP) m_upd++;
         if (up != ut && m_miss < STAT_TOP) m_miss++;
      end
      if (rq) begin
         id4 = IW'(idx);
         exp_q.push_back({id4, m_ctr[idx] >= (1 << (CW - 1))});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0, 0);
   endtask

   // Request in flight when reset hits: it must never be answered.
   task automatic mid_reset();
      @(negedge clk);
      req_valid = 1'b1; req_pc = $urandom; upd_valid = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      logic [IW:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (pred_valid) begin
            check("pred_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("pred_idx", int'(pred_idx), int'(e[IW:1]));
               check("pred_taken", int'(pred_taken), int'(e[0]));
               last_idx = int'(e[IW:1]);
            end
         end else begin
            check("pred_missing", int'(exp_q.size()), 0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            check("idle_taken", int'(pred_taken), 0);
            check("idle_idx_hold", int'(pred_idx), last_idx);
         end
         check("stat_upd", int'(stat_upd), m_upd);
         check("stat_miss", int'(stat_miss), m_miss);
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state: pc 0x0C -> idx 3, not taken
      cyc(1, 32'h0C, 0, '0, 0, 0);
      idle(1);

      // saturate up then down on idx 3, probing pc 0x0C each step
      for (int i = 0; i < 4; i++) begin
         cyc(0, '0, 1, 4'd3, 1, 1);
         cyc(1, 32'h0C, 0, '0, 0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, '0, 1, 4'd3, 0, 0);
         cyc(1, 32'h0C, 0, '0, 0, 0);
      end

      // same-cycle update visible to the request
      mid_reset();
      cyc(0, '0, 1, 4'd3, 1, 1);
      cyc(0, '0, 1, 4'd3, 0, 0);
      cyc(0, '0, 1, 4'd3, 1, 1);
      cyc(1, 32'h0C, 1, 4'd3, 1, 1);
      idle(1);

      // history: taken, not-taken -> ghr 2'b10, pc 0x0C -> idx 1
      mid_reset();
      cyc(0, '0, 1, 4'd7, 1, 1);
      cyc(0, '0, 1, 4'd7, 0, 0);
      cyc(1, 32'h0C, 0, '0, 0, 0);
      idle(1);

      // stat saturation: 9 mispredictions on 3-bit counters
      mid_reset();
      for (int i = 0; i < 9; i++) cyc(0, '0, 1, IW'(i), i[0], ~i[0]);
      idle(1);

      // reset with request in flight, then all counters read back as 0
      mid_reset();
      for (int i = 0; i < NE; i++) cyc(1, 32'(i * 4), 0, '0, 0, 0);
      idle(1);

      for (int n = 0; n < 1500; n++) begin
         if (n % 400 == 399) mid_reset();
         cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
             IW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      idle(2);
      check("queue_drained", int'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
